// File: rtl/mem_copy_sequencer.sv
// rtl/mem_copy_sequencer.sv - bank-to-bank bulk copy sequencer for the 8-bank polynomial memory
//
// Purpose:
//   Copies one full source bank into a destination bank. Both core ports are
//   driven in parallel, one word per core per cycle. The memory has a 1-cycle
//   read latency, so each word is written on the cycle after its read is issued.
//   While i_cpu_interrupt is high the CPU owns the memory selects: the sequencer
//   does not write, and a write that was about to land is re-read after release.
//
// Optional feature (macro MEM_COPY_ZERO_FILL_EN):
//   Adds i_zero_fill. A zero-fill request writes zeros to every word of the
//   destination bank, with no read phase and with mem_rd_sel held at 0.
//
// Ports:
//   i_clk, i_resetn               clock, asynchronous active-low reset
//   i_start                       request pulse, sampled only in IDLE
//   i_src_sel, i_dst_sel          source/destination bank (1..8), sampled with i_start
//   i_cpu_interrupt               CPU owns the memory selects; the sequencer stalls
//   i_zero_fill                   (MEM_COPY_ZERO_FILL_EN only) zero-fill request flag
//   o_busy, o_done, o_err         status: active transfer, completion pulse, reject pulse
//   o_mem_rd_sel, o_mem_wr_sel    emulator-side bank selects, 0 when idle
//   o_core{0,1}_rd_addr           read address (both cores identical)
//   o_core{0,1}_wr_addr           write address (both cores identical)
//   o_core{0,1}_wr_en             byte-lane write enables, 8'hFF on a write
//   i_core{0,1}_rd_data           read data, valid 1 cycle after the address
//   o_core{0,1}_wr_data           write data, pass-through of the matching read data

module mem_copy_sequencer #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048,
  parameter int DATA_W = 60
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_start,
  input  logic [3:0]        i_src_sel,
  input  logic [3:0]        i_dst_sel,
  input  logic              i_cpu_interrupt,
`ifdef MEM_COPY_ZERO_FILL_EN
  input  logic              i_zero_fill,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [3:0]        o_mem_rd_sel,
  output logic [3:0]        o_mem_wr_sel,
  output logic [ADDR_W-1:0] o_core0_rd_addr,
  output logic [ADDR_W-1:0] o_core1_rd_addr,
  output logic [ADDR_W-1:0] o_core0_wr_addr,
  output logic [ADDR_W-1:0] o_core1_wr_addr,
  output logic [7:0]        o_core0_wr_en,
  output logic [7:0]        o_core1_wr_en,
  input  logic [DATA_W-1:0] i_core0_rd_data,
  input  logic [DATA_W-1:0] i_core1_rd_data,
  output logic [DATA_W-1:0] o_core0_wr_data,
  output logic [DATA_W-1:0] o_core1_wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_rd_ptr, w_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr;
  logic              r_inflight, w_inflight;
  logic [3:0]        r_src, w_src;
  logic [3:0]        r_dst, w_dst;
  logic              r_zf, w_zf;

  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_err, w_err;
  logic [3:0]        r_rd_sel, w_rd_sel;
  logic [3:0]        r_wr_sel, w_wr_sel;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr;
  logic [7:0]        r_wr_en, w_wr_en;
  // High on copy writes only: wr_data is forced to 0 otherwise (idle, reset, zero-fill).
  logic              r_pass, w_pass;

  logic              w_zf_req;
  logic              w_src_ok;
  logic              w_dst_ok;
  logic              w_req_ok;
  logic              w_stall;

`ifdef MEM_COPY_ZERO_FILL_EN
  assign w_zf_req = i_zero_fill;
`else
  assign w_zf_req = 1'b0;
`endif

  assign w_src_ok = (i_src_sel >= 4'd1) && (i_src_sel <= 4'd8);
  assign w_dst_ok = (i_dst_sel >= 4'd1) && (i_dst_sel <= 4'd8);
  assign w_req_ok = w_zf_req ? w_dst_ok : (w_src_ok && w_dst_ok && (i_src_sel != i_dst_sel));
  assign w_stall  = i_cpu_interrupt;

  always_comb begin
    w_state    = r_state;
    w_rd_ptr   = r_rd_ptr;
    w_wr_ptr   = r_wr_ptr;
    w_inflight = r_inflight;
    w_src      = r_src;
    w_dst      = r_dst;
    w_zf       = r_zf;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_rd_sel   = r_rd_sel;
    w_wr_sel   = r_wr_sel;
    w_rd_addr  = r_rd_addr;
    w_wr_addr  = r_wr_addr;
    w_wr_en    = 8'h00;
    w_pass     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_busy   = 1'b0;
        w_rd_sel = 4'd0;
        w_wr_sel = 4'd0;
        // r_done high means this is the done-pulse cycle; a start here is dropped.
        if (i_start && !r_done) begin
          if (w_req_ok) begin
            w_src      = i_src_sel;
            w_dst      = i_dst_sel;
            w_zf       = w_zf_req;
            w_rd_ptr   = '0;
            w_wr_ptr   = '0;
            w_inflight = 1'b0;
            w_state    = ST_RUN;
          end else begin
            w_err = 1'b1;
          end
        end
      end

      ST_RUN: begin
        w_busy   = 1'b1;
        w_rd_sel = r_zf ? 4'd0 : r_src;
        w_wr_sel = r_dst;
        if (w_stall) begin
          // The pending write would land while the CPU owns the select: drop it
          // and rewind so that word is read again after release.
          if (r_inflight) begin
            w_rd_ptr   = r_wr_ptr;
            w_inflight = 1'b0;
          end
        end else if (r_zf) begin
          w_wr_en   = 8'hFF;
          w_wr_addr = r_rd_ptr;
          if (r_rd_ptr == LAST_ADDR) begin
            w_state = ST_FIN;
          end else begin
            w_rd_ptr = r_rd_ptr + 1'b1;
          end
        end else begin
          if (r_inflight) begin
            w_wr_en   = 8'hFF;
            w_wr_addr = r_wr_ptr;
            w_pass    = 1'b1;
          end
          w_rd_addr  = r_rd_ptr;
          w_wr_ptr   = r_rd_ptr;
          w_inflight = 1'b1;
          if (r_rd_ptr == LAST_ADDR) begin
            w_state = ST_DRAIN;
          end else begin
            w_rd_ptr = r_rd_ptr + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        w_busy   = 1'b1;
        w_rd_sel = r_src;
        w_wr_sel = r_dst;
        if (w_stall) begin
          // Last word dropped: go back and re-issue it (rd_ptr becomes DEPTH-1).
          w_rd_ptr   = r_wr_ptr;
          w_inflight = 1'b0;
          w_state    = ST_RUN;
        end else begin
          w_wr_en    = 8'hFF;
          w_wr_addr  = r_wr_ptr;
          w_pass     = 1'b1;
          w_inflight = 1'b0;
          w_state    = ST_FIN;
        end
      end

      ST_FIN: begin
        w_done   = 1'b1;
        w_busy   = 1'b0;
        w_rd_sel = 4'd0;
        w_wr_sel = 4'd0;
        w_state  = ST_IDLE;
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state    <= ST_IDLE;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_inflight <= 1'b0;
      r_src      <= 4'd0;
      r_dst      <= 4'd0;
      r_zf       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_sel   <= 4'd0;
      r_wr_sel   <= 4'd0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_en    <= 8'h00;
      r_pass     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_rd_ptr   <= w_rd_ptr;
      r_wr_ptr   <= w_wr_ptr;
      r_inflight <= w_inflight;
      r_src      <= w_src;
      r_dst      <= w_dst;
      r_zf       <= w_zf;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
      r_rd_sel   <= w_rd_sel;
      r_wr_sel   <= w_wr_sel;
      r_rd_addr  <= w_rd_addr;
      r_wr_addr  <= w_wr_addr;
      r_wr_en    <= w_wr_en;
      r_pass     <= w_pass;
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_mem_rd_sel    = r_rd_sel;
  assign o_mem_wr_sel    = r_wr_sel;
  assign o_core0_rd_addr = r_rd_addr;
  assign o_core1_rd_addr = r_rd_addr;
  assign o_core0_wr_addr = r_wr_addr;
  assign o_core1_wr_addr = r_wr_addr;
  assign o_core0_wr_en   = r_wr_en;
  assign o_core1_wr_en   = r_wr_en;
  assign o_core0_wr_data = r_pass ? i_core0_rd_data : '0;
  assign o_core1_wr_data = r_pass ? i_core1_rd_data : '0;

endmodule

// File: tb/tb_mem_copy_sequencer.sv
// tb/tb_mem_copy_sequencer.sv - self-checking bench for mem_copy_sequencer

module tb_mem_copy_sequencer;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;
  localparam int DATA_W = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn;
  logic              start;
  logic [3:0]        src_sel;
  logic [3:0]        dst_sel;
  logic              cpu_int;
`ifdef MEM_COPY_ZERO_FILL_EN
  logic              zero_fill;
`endif
  logic              busy, done, err;
  logic [3:0]        rd_sel, wr_sel;
  logic [ADDR_W-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [7:0]        wr_en0, wr_en1;
  logic [DATA_W-1:0] rd_data0, rd_data1, wr_data0, wr_data1;

  int total = 0;
  int bad   = 0;

  mem_copy_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .i_clk           (clk),
    .i_resetn        (resetn),
    .i_start         (start),
    .i_src_sel       (src_sel),
    .i_dst_sel       (dst_sel),
    .i_cpu_interrupt (cpu_int),
`ifdef MEM_COPY_ZERO_FILL_EN
    .i_zero_fill     (zero_fill),
`endif
    .o_busy          (busy),
    .o_done          (done),
    .o_err           (err),
    .o_mem_rd_sel    (rd_sel),
    .o_mem_wr_sel    (wr_sel),
    .o_core0_rd_addr (rd_addr0),
    .o_core1_rd_addr (rd_addr1),
    .o_core0_wr_addr (wr_addr0),
    .o_core1_wr_addr (wr_addr1),
    .o_core0_wr_en   (wr_en0),
    .o_core1_wr_en   (wr_en1),
    .i_core0_rd_data (rd_data0),
    .i_core1_rd_data (rd_data1),
    .o_core0_wr_data (wr_data0),
    .o_core1_wr_data (wr_data1)
  );

  // Reference contents; the memory model below holds what the DUT actually wrote.
  logic [DATA_W-1:0] gold0 [1:8][0:DEPTH-1];
  logic [DATA_W-1:0] gold1 [1:8][0:DEPTH-1];
  logic [DATA_W-1:0] mem0  [1:8][0:DEPTH-1];
  logic [DATA_W-1:0] mem1  [1:8][0:DEPTH-1];
  logic              load_en = 1'b0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int b = 1; b <= 8; b++)
        for (int a = 0; a < DEPTH; a++) begin
          mem0[b][a] <= gold0[b][a];
          mem1[b][a] <= gold1[b][a];
        end
    end else begin
      if (rd_sel >= 4'd1 && rd_sel <= 4'd8) begin
        rd_data0 <= mem0[rd_sel][rd_addr0];
        rd_data1 <= mem1[rd_sel][rd_addr1];
      end else begin
        rd_data0 <= '0;
        rd_data1 <= '0;
      end
      if (wr_sel >= 4'd1 && wr_sel <= 4'd8) begin
        if (wr_en0 == 8'hFF) mem0[wr_sel][wr_addr0] <= wr_data0;
        if (wr_en1 == 8'hFF) mem1[wr_sel][wr_addr1] <= wr_data1;
      end
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
  } wr_t;

  wr_t sb[$];
  wr_t exp_w;

  // Every observed write must be the next expected {address, data} pair.
  always @(negedge clk) begin
    if (resetn && (wr_en0 != 8'h00 || wr_en1 != 8'h00)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: unexpected write addr=%0d en=%h", wr_addr0, wr_en0);
      end else begin
        exp_w = sb.pop_front();
        if (wr_en0 !== 8'hFF || wr_en1 !== 8'hFF || wr_addr0 !== exp_w.addr ||
            wr_addr1 !== exp_w.addr || wr_data0 !== exp_w.d0 || wr_data1 !== exp_w.d1) begin
          bad++;
          $display("FAIL sb_write: got addr=%0d/%0d en=%h/%h d0=%h d1=%h, need addr=%0d en=ff d0=%h d1=%h",
                   wr_addr0, wr_addr1, wr_en0, wr_en1, wr_data0, wr_data1, exp_w.addr, exp_w.d0, exp_w.d1);
        end
      end
    end
  end

  function automatic logic all_out_zero();
    return ({busy, done, err, rd_sel, wr_sel, rd_addr0, rd_addr1, wr_addr0, wr_addr1,
             wr_en0, wr_en1, wr_data0, wr_data1} == '0);
  endfunction

  task automatic check(input string name, input bit ok, input int got, input int need);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%0d need=%0d", name, got, need);
    end
  endtask

  task automatic do_reject(input logic [3:0] src, input logic [3:0] dst);
    int err_n, err_at, busy_n, act_n;
    err_n = 0; err_at = -1; busy_n = 0; act_n = 0;
    @(negedge clk);
    src_sel = src; dst_sel = dst; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (err) begin err_n++; err_at = cyc; end
      if (busy) busy_n++;
      if (wr_en0 != 0 || wr_en1 != 0 || rd_sel != 0 || wr_sel != 0) act_n++;
      @(negedge clk);
    end
    check("reject_err_pulse", err_n == 1 && err_at == 0, err_n * 100 + err_at, 100);
    check("reject_busy", busy_n == 0, busy_n, 0);
    check("reject_mem_activity", act_n == 0, act_n, 0);
  endtask

  task automatic do_copy(input logic [3:0] src, input logic [3:0] dst, input bit zf,
                         input int exp_done, input int stall_at, input int stall_len,
                         input int reset_at);
    int busy_n, done_n, done_at, err_n, stall_wr, rdsel_bad, mism;
    busy_n = 0; done_n = 0; done_at = -1; err_n = 0; stall_wr = 0; rdsel_bad = 0; mism = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (zf) sb.push_back('{ADDR_W'(k), '0, '0});
      else    sb.push_back('{ADDR_W'(k), gold0[src][k], gold1[src][k]});
    end
    @(negedge clk);
    src_sel = src; dst_sel = dst; start = 1'b1;
`ifdef MEM_COPY_ZERO_FILL_EN
    zero_fill = zf;
`endif
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < exp_done + 8; cyc++) begin
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = cyc; end
      if (err) err_n++;
      if (zf && rd_sel != 4'd0) rdsel_bad++;
      if (stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len && wr_en0 != 0) stall_wr++;
      if (stall_len > 0 && cyc == stall_at + stall_len)
        check("stall_reread_addr", rd_addr0 == ADDR_W'(stall_at - 2), int'(rd_addr0), stall_at - 2);
      // cpu_interrupt is sampled at edges stall_at .. stall_at+stall_len-1
      if (stall_len > 0 && cyc == stall_at - 1) cpu_int = 1'b1;
      if (stall_len > 0 && cyc == stall_at + stall_len - 1) cpu_int = 1'b0;
      // start while busy (with an invalid pair) must be ignored without err
      if (cyc == 300) begin start = 1'b1; src_sel = dst; end
      if (cyc == 301) start = 1'b0;
      // start during the done pulse must be ignored
      if (cyc == exp_done) begin start = 1'b1; src_sel = src; end
      if (cyc == exp_done + 1) start = 1'b0;
      if (reset_at != 0 && cyc == reset_at) begin
        #2 resetn = 1'b0;
        #1 check("reset_mid_outputs_zero", all_out_zero(), 0, 1);
        @(negedge clk);
        sb.delete();
        start = 1'b0;
        cpu_int = 1'b0;
        resetn = 1'b1;
        return;
      end
      @(negedge clk);
    end
    check("done_pulse", done_n == 1 && done_at == exp_done, done_at, exp_done);
    check("busy_len", busy_n == exp_done - 1, busy_n, exp_done - 1);
    check("no_err_during_copy", err_n == 0, err_n, 0);
    check("sb_empty", sb.size() == 0, sb.size(), 0);
    if (stall_len > 0) check("no_wr_during_stall", stall_wr == 0, stall_wr, 0);
    if (zf) check("zf_rd_sel_zero", rdsel_bad == 0, rdsel_bad, 0);
    for (int a = 0; a < DEPTH; a++) begin
      if (zf) begin
        if (mem0[dst][a] !== '0 || mem1[dst][a] !== '0) mism++;
      end else begin
        if (mem0[dst][a] !== gold0[src][a] || mem1[dst][a] !== gold1[src][a]) mism++;
      end
    end
    check("dst_bank_contents", mism == 0, mism, 0);
    for (int a = 0; a < DEPTH; a++) begin
      gold0[dst][a] = zf ? '0 : gold0[src][a];
      gold1[dst][a] = zf ? '0 : gold1[src][a];
    end
    sb.delete();
  endtask

  typedef struct {
    logic [3:0] src;
    logic [3:0] dst;
    bit         exp_err;
    int         exp_done;
    int         stall_at;
    int         stall_len;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{4'd4, 4'd4, 1'b1, 0,    0,    0};
    vt[1] = '{4'd0, 4'd2, 1'b1, 0,    0,    0};
    vt[2] = '{4'd9, 4'd1, 1'b1, 0,    0,    0};
    vt[3] = '{4'd2, 4'd0, 1'b1, 0,    0,    0};
    vt[4] = '{4'd3, 4'd5, 1'b0, 2050, 0,    0};
    vt[5] = '{4'd1, 4'd6, 1'b0, 2056, 100,  5};
    vt[6] = '{4'd2, 4'd7, 1'b0, 2052, 2049, 1};

    resetn = 1'b0; start = 1'b0; src_sel = 4'd0; dst_sel = 4'd0; cpu_int = 1'b0;
`ifdef MEM_COPY_ZERO_FILL_EN
    zero_fill = 1'b0;
`endif
    for (int b = 1; b <= 8; b++)
      for (int a = 0; a < DEPTH; a++) begin
        gold0[b][a] = {4'(b), 11'(a), 45'($urandom)};
        gold1[b][a] = {4'(b), 11'(a ^ 11'h5A5), 45'($urandom)};
      end
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs_zero", all_out_zero(), 0, 1);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs_zero", all_out_zero(), 0, 1);

    for (int i = 0; i < 7; i++) begin
      if (vt[i].exp_err) do_reject(vt[i].src, vt[i].dst);
      else do_copy(vt[i].src, vt[i].dst, 1'b0, vt[i].exp_done, vt[i].stall_at, vt[i].stall_len, 0);
    end

    do_copy(4'd4, 4'd8, 1'b0, 2050, 0, 0, 500);
    repeat (3) @(negedge clk);
    check("post_reset_idle", all_out_zero(), 0, 1);
    do_copy(4'd4, 4'd8, 1'b0, 2050, 0, 0, 0);

`ifdef MEM_COPY_ZERO_FILL_EN
    do_copy(4'd3, 4'd2, 1'b1, 2049, 0, 0, 0);
    zero_fill = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
